// File: rtl/csm_share_scheduler.sv
// Round-robin scheduler sharing one 8x8 unsigned carry-save array multiplier
// between NREQ requesters, with a fixed settle count and a held response.

module csm_pp_array (
    input  logic [7:0]  m,
    input  logic [7:0]  q,
    output logic [15:0] product
);

    logic [15:0] s;
    logic [15:0] c;
    logic [15:0] pp;
    logic [15:0] s_n;

    // Each partial-product row is folded into a sum/carry pair; only the final add ripples.
    always_comb begin
        s   = '0;
        c   = '0;
        pp  = '0;
        s_n = '0;
        for (int i = 0; i < 8; i++) begin
            pp  = q[i] ? ({8'b0, m} << i) : 16'b0;
            s_n = s ^ c ^ pp;
            c   = ((s & c) | (s & pp) | (c & pp)) << 1;
            s   = s_n;
        end
        product = s + c;
    end

endmodule

module csm_share_scheduler #(
    parameter  int NREQ     = 4,
    parameter  int MULT_LAT = 2,
    parameter  int COUNT_W  = 16,
    localparam int ID_W     = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_m,
    input  logic [NREQ*8-1:0]   req_q,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [15:0]         rsp_product,
    output logic                busy,
    output logic [COUNT_W-1:0]  done_count
);

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_reg;
    logic [7:0]        m_reg;
    logic [7:0]        q_reg;
    logic [CNT_W-1:0]  cnt;
    logic              any_valid;
    logic [ID_W-1:0]   grant;
    logic [7:0]        sel_m;
    logic [7:0]        sel_q;
    logic              accept;
    logic [15:0]       array_product;
    int                idx;

    // The array only ever sees the captured operands, so live bus changes cannot disturb it.
    csm_pp_array u_array (
        .m       (m_reg),
        .q       (q_reg),
        .product (array_product)
    );

    // Search starts at rr_ptr and wraps, so the last-served requester drops to lowest priority.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        sel_m     = '0;
        sel_q     = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = ID_W'(idx);
                sel_m     = req_m[8*idx +: 8];
                sel_q     = req_q[8*idx +: 8];
            end
        end
    end

    assign accept = (state == IDLE) && any_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (any_valid) next_state = BUSY;
            BUSY: if (cnt == '0) next_state = RESP;
            RESP: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Reset clears everything, so an operation in flight simply vanishes without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            id_reg      <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            done_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_reg  <= sel_m;
                        q_reg  <= sel_q;
                        id_reg <= grant;
                        cnt    <= CNT_W'(MULT_LAT - 1);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_product <= array_product;
                        rsp_id      <= id_reg;
                        rsp_valid   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rr_ptr     <= (id_reg == ID_W'(NREQ - 1)) ? '0 : id_reg + ID_W'(1);
                        done_count <= done_count + COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csm_share_scheduler.sv
// Randomized self-checking bench for csm_share_scheduler against a transaction-level
// model: round-robin pointer, plain multiplication and a wrapping completion count.

module tb_csm_share_scheduler;

    localparam int NREQ     = 4;
    localparam int MULT_LAT = 2;
    localparam int COUNT_W  = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_m;
    logic [NREQ*8-1:0] req_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_product;
    logic              busy;
    logic [COUNT_W-1:0] done_count;

    int          checkCount;
    int          errCount;
    int          modelPtr;
    logic [3:0]  modelDone;
    logic [15:0] modelProd;

    csm_share_scheduler #(
        .NREQ     (NREQ),
        .MULT_LAT (MULT_LAT),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_m       (req_m),
        .req_q       (req_q),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pickGrant(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return 0;
    endfunction

    // One full transaction: grant, settle, optional response stall, handshake.
    task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] ms,
                                 input logic [31:0] qs, input int stall);
        int          g;
        int          lat;
        logic [3:0]  oh;
        logic [15:0] eprod;
        g     = pickGrant(mask, modelPtr);
        oh    = 4'(1 << g);
        eprod = 16'(ms[8*g +: 8]) * 16'(qs[8*g +: 8]);
        req_valid = mask;
        req_m     = ms;
        req_q     = qs;
        rsp_ready = (stall == 0);
        #1;
        checkOutput("grant", 32'(req_ready), 32'(oh));
        @(posedge clk);
        #1;
        req_valid = mask & ~oh;
        req_m     = $urandom;
        req_q     = $urandom;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            checkOutput("busy_ready", 32'(req_ready), 32'(0));
        end
        checkOutput("latency", 32'(lat), 32'(MULT_LAT + 1));
        checkOutput("rsp_id", 32'(rsp_id), 32'(g));
        checkOutput("product", 32'(rsp_product), 32'(eprod));
        checkOutput("busy_resp", 32'(busy), 32'(1));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'(1));
            checkOutput("hold_product", 32'(rsp_product), 32'(eprod));
            checkOutput("hold_ready", 32'(req_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        modelDone = modelDone + 4'd1;
        modelPtr  = (g + 1) % NREQ;
        modelProd = eprod;
        checkOutput("post_valid", 32'(rsp_valid), 32'(0));
        checkOutput("done_count", 32'(done_count), 32'(modelDone));
        checkOutput("kept_product", 32'(rsp_product), 32'(modelProd));
        checkOutput("post_busy", 32'(busy), 32'(0));
        req_valid = '0;
    endtask

    // Accept an operation, then reset while it is still busy or already responding.
    task automatic resetMid(input int inResp);
        logic [3:0] mask;
        logic [3:0] oh;
        mask = 4'($urandom_range(1, 15));
        oh   = 4'(1 << pickGrant(mask, modelPtr));
        req_valid = mask;
        req_m     = $urandom;
        req_q     = $urandom;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = mask & ~oh;
        if (inResp != 0) begin
            repeat (MULT_LAT + 1) @(negedge clk);
            checkOutput("pre_rst_valid", 32'(rsp_valid), 32'(1));
        end else begin
            @(negedge clk);
            checkOutput("pre_rst_busy", 32'(busy), 32'(1));
        end
        reset     = 1'b1;
        req_valid = 4'hF;
        #1;
        checkOutput("rst_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        modelPtr  = 0;
        modelDone = '0;
        modelProd = '0;
        checkOutput("rst_valid", 32'(rsp_valid), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_done", 32'(done_count), 32'(0));
        checkOutput("rst_product", 32'(rsp_product), 32'(0));
        checkOutput("rst_id", 32'(rsp_id), 32'(0));
        repeat (4) begin
            @(negedge clk);
            checkOutput("no_rsp", 32'(rsp_valid), 32'(0));
        end
    endtask

    initial begin
        logic [31:0] ms;
        logic [31:0] qs;
        checkCount = 0;
        errCount   = 0;
        modelPtr   = 0;
        modelDone  = '0;
        modelProd  = '0;
        clk        = 1'b0;
        reset      = 1'b1;
        req_valid  = 4'hF;
        req_m      = $urandom;
        req_q      = $urandom;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("init_ready", 32'(req_ready), 32'(0));
        checkOutput("init_valid", 32'(rsp_valid), 32'(0));
        checkOutput("init_busy", 32'(busy), 32'(0));
        checkOutput("init_done", 32'(done_count), 32'(0));
        checkOutput("init_product", 32'(rsp_product), 32'(0));
        checkOutput("init_id", 32'(rsp_id), 32'(0));
        reset     = 1'b0;
        req_valid = '0;

        // All requesters pending: service rotates 0,1,2,3,0.
        repeat (5) applyStimulus(4'hF, $urandom, $urandom, 0);

        ms = $urandom; qs = $urandom;
        ms[23:16] = 8'h0C; qs[23:16] = 8'h0A;
        applyStimulus(4'b0100, ms, qs, 0);

        ms = $urandom; qs = $urandom;
        ms[15:8] = 8'hFF; qs[15:8] = 8'hFF;
        applyStimulus(4'b0010, ms, qs, 10);

        resetMid(0);
        applyStimulus(4'hF, $urandom, $urandom, 0);
        resetMid(1);
        applyStimulus(4'hF, $urandom, $urandom, 1);

        // Long random run carries the 4-bit completion count through its wrap.
        for (int i = 0; i < 18; i++) begin
            ms = $urandom; qs = $urandom;
            if (i == 5) begin
                ms[7:0] = 8'h00; qs[7:0] = 8'h37;
                applyStimulus(4'b0001, ms, qs, 0);
            end else begin
                applyStimulus(4'($urandom_range(1, 15)), ms, qs, int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
